// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, transmitter state encoding and the divisor clamp helper.
package uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // A zero divisor would give a zero-length bit, so it is stored as one.
  function automatic logic [15:0] clampDivisor(input logic [15:0] value);
    return (value == 16'd0) ? 16'd1 : value;
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; a push while
// full and a pop while empty are ignored, and flush empties it at once.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_level == (AW+1)'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_data   = r_mem[r_rptr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Flush discards everything, including a push arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_doPop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= r_level + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter (8N1, LSB first) behind a TX FIFO.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  output logic        uart_tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   r_state;
  logic        r_tx;
  logic [15:0] r_baud;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_shift;
  logic [15:0] r_divisor;
  logic [31:0] r_rdData;
  logic        r_rdPhase;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic          w_wrReq;
  logic          w_rdReq;
  logic [1:0]    w_regSel;
  logic          w_dataWr;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_bitDone;
  logic [LW-1:0] w_level;
  logic [7:0]    w_fifoData;
  logic [15:0]   w_divM1;
  logic [31:0]   w_status;
  logic [31:0]   w_rdValue;
  logic          w_unused;

  assign w_unused = ^{dmem_address[31:4], dmem_address[1:0], dmem_write_mode,
                      dmem_read_mode, dmem_write_data[31:16]};

  assign w_regSel  = dmem_address[3:2];
  assign w_wrReq   = dmem_enable && dmem_write_enable;
  assign w_rdReq   = dmem_enable && dmem_read_enable && !dmem_write_enable;
  assign w_dataWr  = w_wrReq && (w_regSel == REG_DATA);
  assign w_push    = w_dataWr && !w_full;
  assign w_flush   = w_wrReq && (w_regSel == REG_CTRL) && dmem_write_data[0];
  assign w_bitDone = (r_baud == 16'd0);
  assign w_divM1   = r_divisor - 16'd1;
  assign w_busy    = (r_state != IDLE) || !w_empty;
  assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bitDone));

  // A stalled store keeps wait high; a load stalls only in its first cycle.
  assign dmem_wait      = (w_dataWr && w_full) || (w_rdReq && !r_rdPhase);
  assign dmem_read_data = r_rdData;
  assign uart_tx        = r_tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (dmem_write_data[7:0]),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_status = {16'd0, 8'(w_level), 5'd0, w_busy, w_empty, w_full};

  always_comb begin
    w_rdValue = 32'd0;
    case (w_regSel)
      REG_STATUS:  w_rdValue = w_status;
      REG_DIVISOR: w_rdValue = {16'd0, r_divisor};
      default:     w_rdValue = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divisor <= DEFAULT_DIV;
      r_rdData  <= 32'd0;
      r_rdPhase <= 1'b0;
    end else begin
      if (w_wrReq && (w_regSel == REG_DIVISOR)) begin
        r_divisor <= clampDivisor(dmem_write_data[15:0]);
      end
      if (w_rdReq && !r_rdPhase) begin
        r_rdData  <= w_rdValue;
        r_rdPhase <= 1'b1;
      end else begin
        r_rdPhase <= 1'b0;
      end
    end
  end

  // Every bit start reloads the baud counter from the current divisor, so a
  // divisor write only changes the bit that begins after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_baud   <= 16'd0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'd0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= START;
            r_tx     <= 1'b0;
            r_shift  <= w_fifoData;
            r_baud   <= w_divM1;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_fifoData;
`endif
          end
        end
        START: begin
          if (w_bitDone) begin
            r_state  <= DATA;
            r_tx     <= r_shift[0];
            r_bitIdx <= 3'd0;
            r_baud   <= w_divM1;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        DATA: begin
          if (w_bitDone) begin
            r_baud <= w_divM1;
            if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        PARITY: begin
          if (w_bitDone) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_baud  <= w_divM1;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        STOP: begin
          if (w_bitDone) begin
            if (w_pop) begin
              r_state  <= START;
              r_tx     <= 1'b0;
              r_shift  <= w_fifoData;
              r_baud   <= w_divM1;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_fifoData;
`endif
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: a frame-level line model plus
// directed bus sequences with hand-computed expectations.
module tb_uart_tx_port;

  localparam int DEPTH   = 16;
  localparam int DEF_DIV = 434;
`ifdef UART_TX_PARITY_EN
  localparam int LASTBIT = 10;
`else
  localparam int LASTBIT = 9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic [31:0] dmem_write_data;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic        uart_tx;

  int checkCount = 0;
  int passCount  = 0;

  uart_tx_port #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'(DEF_DIV))
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .dmem_address      (dmem_address),
    .dmem_enable       (dmem_enable),
    .dmem_write_enable (dmem_write_enable),
    .dmem_write_mode   (dmem_write_mode),
    .dmem_write_data   (dmem_write_data),
    .dmem_read_enable  (dmem_read_enable),
    .dmem_read_mode    (dmem_read_mode),
    .dmem_read_data    (dmem_read_data),
    .dmem_wait         (dmem_wait),
    .uart_tx           (uart_tx)
  );

  always #5 clk = ~clk;

  // Line model: a byte queue and the current frame as (bit number, clocks
  // left in that bit); bit 0 is the start bit and LASTBIT the stop bit.
  logic [7:0]  mQ[$];
  bit          mActive;
  int          mBit;
  int          mRemain;
  logic [7:0]  mByte;
  int          mDiv;
  logic [31:0] mRdData;
  bit          mRdPhase;
  bit          modelLive = 1'b0;

  function automatic logic expTx();
    if (!mActive) return 1'b1;
    if (mBit == 0) return 1'b0;
    if (mBit <= 8) return mByte[mBit-1];
    if (mBit == LASTBIT) return 1'b1;
    return ^mByte;
  endfunction

  function automatic logic [31:0] mStatus();
    logic full;
    logic empty;
    logic busy;
    full  = (mQ.size() == DEPTH);
    empty = (mQ.size() == 0);
    busy  = mActive || (mQ.size() != 0);
    return {16'd0, 8'(mQ.size()), 5'd0, busy, empty, full};
  endfunction

  function automatic logic expWait();
    bit wr;
    bit rd;
    wr = dmem_enable && dmem_write_enable;
    rd = dmem_enable && dmem_read_enable && !dmem_write_enable;
    return (wr && dmem_address[3:2] == 2'd0 && mQ.size() == DEPTH) || (rd && !mRdPhase);
  endfunction

  // Advance the model by one clock from the pre-edge inputs.
  always @(posedge clk) begin
    if (reset) begin
      mQ.delete();
      mActive   = 1'b0;
      mBit      = 0;
      mRemain   = 0;
      mByte     = 8'd0;
      mDiv      = DEF_DIV;
      mRdData   = 32'd0;
      mRdPhase  = 1'b0;
      modelLive = 1'b1;
    end else begin
      bit          wr;
      bit          rd;
      bit          full;
      logic [1:0]  sel;
      logic [31:0] regVal;
      wr   = dmem_enable && dmem_write_enable;
      rd   = dmem_enable && dmem_read_enable && !dmem_write_enable;
      sel  = dmem_address[3:2];
      full = (mQ.size() == DEPTH);
      regVal = (sel == 2'd1) ? mStatus() : (sel == 2'd2) ? 32'(mDiv) : 32'd0;
      if (rd && !mRdPhase) begin
        mRdData  = regVal;
        mRdPhase = 1'b1;
      end else begin
        mRdPhase = 1'b0;
      end
      if (!mActive) begin
        if (mQ.size() > 0) begin
          mByte = mQ.pop_front();
          mActive = 1'b1; mBit = 0; mRemain = mDiv;
        end
      end else begin
        mRemain--;
        if (mRemain == 0) begin
          mBit++;
          if (mBit > LASTBIT) begin
            if (mQ.size() > 0) begin
              mByte = mQ.pop_front();
              mBit = 0; mRemain = mDiv;
            end else begin
              mActive = 1'b0;
            end
          end else begin
            mRemain = mDiv;
          end
        end
      end
      if (wr && sel == 2'd3 && dmem_write_data[0]) mQ.delete();
      else if (wr && sel == 2'd0 && !full) mQ.push_back(dmem_write_data[7:0]);
      if (wr && sel == 2'd2) mDiv = (dmem_write_data[15:0] == 16'd0) ? 1 : int'(dmem_write_data[15:0]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("uart_tx", 32'(uart_tx), 32'(expTx()));
      checkOutput("dmem_wait", 32'(dmem_wait), 32'(expWait()));
      checkOutput("dmem_read_data", dmem_read_data, mRdData);
    end
  end

  // Bus helpers start and end at one time unit after a rising edge.
  task automatic busWrite(input logic [3:0] off, input logic [31:0] data, output int waits);
    dmem_address      = {28'd0, off};
    dmem_write_data   = data;
    dmem_enable       = 1'b1;
    dmem_write_enable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (dmem_wait && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 2000) checkOutput("write_timeout", 32'(dmem_wait), 32'd0);
    @(posedge clk); #1;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] off, output logic [31:0] data, output int waits);
    dmem_address     = {28'd0, off};
    dmem_enable      = 1'b1;
    dmem_read_enable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (dmem_wait && waits < 10) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 10) checkOutput("read_timeout", 32'(dmem_wait), 32'd0);
    data = dmem_read_data;
    @(posedge clk); #1;
    dmem_enable      = 1'b0;
    dmem_read_enable = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    logic [31:0] d;
    int          w;
    int          waits[18];
    int          lowRun;
    logic [10:0] pat;

    // STATUS straight after reset: one stall cycle, then empty only.
    busRead(4'h4, d, w);
    checkOutput("status_after_reset", d, 32'h0000_0002);
    checkOutput("status_read_stall", 32'(w), 32'd1);

    // 0x55 at DIVISOR=4, sampled bit-period by bit-period.
    busWrite(4'h8, 32'd4, w);
    busWrite(4'h0, 32'h55, w);
`ifdef UART_TX_PARITY_EN
    pat = 11'b10010101010;
`else
    pat = 11'b11010101010;
`endif
    @(negedge clk);
    checkOutput("frame55_pre_start", 32'(uart_tx), 32'd1);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      checkOutput("frame55_line", 32'(uart_tx), 32'(pat[i/4]));
    end
    @(posedge clk); #1;

`ifdef UART_TX_PARITY_EN
    busWrite(4'h0, 32'h07, w);
    @(negedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (i == 37) checkOutput("parity_07", 32'(uart_tx), 32'd1);
    end
    @(posedge clk); #1;
`endif

    // Zero divisor reads back as one.
    busWrite(4'h8, 32'd0, w);
    busRead(4'h8, d, w);
    checkOutput("divisor_zero_clamp", d, 32'h0000_0001);
    busWrite(4'h8, 32'd4, w);
    idleCycles(10);

    // 18 back-to-back bytes: the first pop makes room for the 17th; the
    // 18th stalls until the second pop and is accepted the cycle after.
    for (int k = 0; k < 18; k++) begin
      busWrite(4'h0, 32'(8'hA0 + k), waits[k]);
    end
    checkOutput("write17_no_stall", 32'(waits[16]), 32'd0);
    checkOutput("write18_stall_cycles", 32'(waits[17]), 32'd25);
    idleCycles(18 * 40);
    busRead(4'h4, d, w);
    checkOutput("status_after_burst", d, 32'h0000_0002);

    // Divisor change mid-frame takes effect at the next bit boundary.
    busWrite(4'h0, 32'hF0, w);
    idleCycles(6);
    busWrite(4'h8, 32'd8, w);
    idleCycles(100);
    busWrite(4'h8, 32'h00FF, w);
    busWrite(4'h0, 32'h01, w);
    @(negedge clk);
    lowRun = 0;
    @(negedge clk);
    while (uart_tx == 1'b0 && lowRun < 1000) begin
      lowRun++;
      @(negedge clk);
    end
    checkOutput("start_bit_255", 32'(lowRun), 32'd255);
    @(posedge clk); #1;
    idleCycles(2600);
    busWrite(4'h8, 32'd4, w);

    // Write and read together: the write wins, no read stall.
    dmem_address      = 32'h8;
    dmem_write_data   = 32'd5;
    dmem_enable       = 1'b1;
    dmem_write_enable = 1'b1;
    dmem_read_enable  = 1'b1;
    @(negedge clk);
    checkOutput("wr_rd_no_stall", 32'(dmem_wait), 32'd0);
    @(posedge clk); #1;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    dmem_read_enable  = 1'b0;
    busRead(4'h8, d, w);
    checkOutput("wr_rd_divisor", d, 32'h0000_0005);
    busWrite(4'h8, 32'd4, w);
    idleCycles(60);

    // Flush during the first of three frames.
    busWrite(4'h0, 32'h11, w);
    busWrite(4'h0, 32'h22, w);
    busWrite(4'h0, 32'h33, w);
    idleCycles(6);
    busWrite(4'hC, 32'd1, w);
    busRead(4'h4, d, w);
    checkOutput("status_after_flush", d, 32'h0000_0006);
    idleCycles(50);
    busRead(4'h4, d, w);
    checkOutput("status_flush_done", d, 32'h0000_0002);

    // Reset in the middle of the data bits.
    busWrite(4'h0, 32'h00, w);
    idleCycles(10);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_midframe_tx", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    busRead(4'h4, d, w);
    checkOutput("status_after_midframe_reset", d, 32'h0000_0002);
    idleCycles(20);
  endtask

  initial begin
    reset             = 1'b1;
    dmem_address      = 32'd0;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    dmem_write_mode   = 3'd2;
    dmem_write_data   = 32'd0;
    dmem_read_enable  = 1'b0;
    dmem_read_mode    = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
